load_store_unit: RTL and testbench

//  Memory stage directly downstream of the ALU. Consumes the ALU memory op:

---
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory stage that sits directly behind the ALU. It accepts one memory op
//   at a time, drives a single-outstanding req/gnt/rvalid data-memory port,
//   and returns byte-lane extracted, sign/zero extended load data to the
//   register write-back path.
//
// Ports
//   iClk, iRst            clock, synchronous active-high reset
//   iValid/iRead/iWrite   op present, load flag, store flag
//   iAddr, iData          effective byte address, store data
//   iOpType, iRdAddr      funct3, load destination register
//   oReady                idle; op accepted when iValid & oReady
//   oDmemReq/We/Addr/Wdata/Be, iDmemGnt, iDmemRvalid, iDmemRdata
//                         data-memory port
//   oRegDv/oRegAddr/oRegData  write-back (oRegDv is a one-cycle pulse)
//   oErr                  one-cycle pulse for an illegal or dropped op
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word ops are dropped
//                         with oErr; otherwise they are forced to natural
//                         alignment and proceed silently.

module load_store_unit #(
  parameter int cDataWidth = 32,
  parameter int cRegAddrW  = 5
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  input  logic                  iRead,
  input  logic                  iWrite,
  input  logic [cDataWidth-1:0] iAddr,
  input  logic [cDataWidth-1:0] iData,
  input  logic [2:0]            iOpType,
  input  logic [cRegAddrW-1:0]  iRdAddr,
  output logic                  oReady,
  output logic                  oDmemReq,
  output logic                  oDmemWe,
  output logic [cDataWidth-1:0] oDmemAddr,
  output logic [cDataWidth-1:0] oDmemWdata,
  output logic [3:0]            oDmemBe,
  input  logic                  iDmemGnt,
  input  logic                  iDmemRvalid,
  input  logic [cDataWidth-1:0] iDmemRdata,
  output logic                  oRegDv,
  output logic [cRegAddrW-1:0]  oRegAddr,
  output logic [cDataWidth-1:0] oRegData,
  output logic                  oErr
);

  typedef enum logic [1:0] {
    Idle,
    Req,
    Wait
  } lsuState_t;

  lsuState_t                 state;
  logic [2:0]                capOp;
  logic [1:0]                capOff;
  logic [cRegAddrW-1:0]      capRd;

  logic                      opLegal;
  logic                      misaligned;
  logic                      acceptOp;
  logic                      dropOp;
  logic [1:0]                alignedOff;
  logic [3:0]                reqBe;
  logic [cDataWidth-1:0]     reqWdata;
  logic [cDataWidth-1:0]     laneWord;
  logic [cDataWidth-1:0]     loadResult;

  // Decode the incoming op: legality of funct3 for the selected direction,
  // natural-alignment check, the lane offset actually used (forced aligned
  // for half/word), and the byte enables / replicated store data that will
  // be registered onto the memory port when the op is accepted.
  always_comb begin
    opLegal    = 1'b0;
    misaligned = 1'b0;
    alignedOff = iAddr[1:0];
    reqBe      = 4'b1111;
    reqWdata   = iData;

    if (iRead && !iWrite) begin
      case (iOpType)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: opLegal = 1'b1;
        default:                                opLegal = 1'b0;
      endcase
    end else if (iWrite && !iRead) begin
      case (iOpType)
        3'b000, 3'b001, 3'b010: opLegal = 1'b1;
        default:                opLegal = 1'b0;
      endcase
    end

    case (iOpType[1:0])
      2'b00: begin
        reqBe    = 4'b0001 << alignedOff;
        reqWdata = {4{iData[7:0]}};
      end
      2'b01: begin
        misaligned    = iAddr[0];
        alignedOff[0] = 1'b0;
        reqBe         = 4'b0011 << alignedOff;
        reqWdata      = {2{iData[15:0]}};
      end
      default: begin
        misaligned = |iAddr[1:0];
        alignedOff = 2'b00;
        reqBe      = 4'b1111;
        reqWdata   = iData;
      end
    endcase

`ifdef LSU_MISALIGN_TRAP_EN
    acceptOp = iValid && opLegal && !misaligned;
    dropOp   = iValid && (iRead || iWrite) && (!opLegal || misaligned);
`else
    acceptOp = iValid && opLegal;
    dropOp   = iValid && (iRead || iWrite) && !opLegal;
`endif
  end

  // Load lane extraction: shift the addressed byte/half down to bit 0, then
  // sign- or zero-extend according to the captured funct3.
  always_comb begin
    laneWord   = iDmemRdata >> {capOff, 3'b000};
    loadResult = laneWord;
    case (capOp)
      3'b000:  loadResult = {{24{laneWord[7]}}, laneWord[7:0]};
      3'b001:  loadResult = {{16{laneWord[15]}}, laneWord[15:0]};
      3'b100:  loadResult = {24'd0, laneWord[7:0]};
      3'b101:  loadResult = {16'd0, laneWord[15:0]};
      default: loadResult = laneWord;
    endcase
  end

  // Main FSM. Every port output is registered here. The memory request is
  // held stable from acceptance until grant; oDmemWe doubles as the
  // "this is a store" flag for the grant decision. oRegDv and oErr are
  // cleared every cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= Idle;
      capOp      <= 3'd0;
      capOff     <= 2'd0;
      capRd      <= '0;
      oReady     <= 1'b1;
      oDmemReq   <= 1'b0;
      oDmemWe    <= 1'b0;
      oDmemAddr  <= '0;
      oDmemWdata <= '0;
      oDmemBe    <= 4'd0;
      oRegDv     <= 1'b0;
      oRegAddr   <= '0;
      oRegData   <= '0;
      oErr       <= 1'b0;
    end else begin
      oRegDv <= 1'b0;
      oErr   <= 1'b0;
      case (state)
        Idle: begin
          if (acceptOp) begin
            state      <= Req;
            capOp      <= iOpType;
            capOff     <= alignedOff;
            capRd      <= iRdAddr;
            oReady     <= 1'b0;
            oDmemReq   <= 1'b1;
            oDmemWe    <= iWrite;
            oDmemAddr  <= {iAddr[cDataWidth-1:2], 2'b00};
            oDmemWdata <= reqWdata;
            oDmemBe    <= reqBe;
          end else if (dropOp) begin
            oErr <= 1'b1;
          end
        end
        Req: begin
          if (iDmemGnt) begin
            oDmemReq <= 1'b0;
            if (oDmemWe) begin
              state  <= Idle;
              oReady <= 1'b1;
            end else begin
              state <= Wait;
            end
          end
        end
        Wait: begin
          if (iDmemRvalid) begin
            state    <= Idle;
            oReady   <= 1'b1;
            oRegData <= loadResult;
            oRegAddr <= capRd;
            oRegDv   <= (capRd != '0);
          end
        end
        default: begin
          state  <= Idle;
          oReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit. Each scenario task drives the DUT
//   and compares observed outputs against hand-computed values inline.

module tb_load_store_unit;

  logic        iClk;
  logic        iRst;
  logic        iValid;
  logic        iRead;
  logic        iWrite;
  logic [31:0] iAddr;
  logic [31:0] iData;
  logic [2:0]  iOpType;
  logic [4:0]  iRdAddr;
  logic        oReady;
  logic        oDmemReq;
  logic        oDmemWe;
  logic [31:0] oDmemAddr;
  logic [31:0] oDmemWdata;
  logic [3:0]  oDmemBe;
  logic        iDmemGnt;
  logic        iDmemRvalid;
  logic [31:0] iDmemRdata;
  logic        oRegDv;
  logic [4:0]  oRegAddr;
  logic [31:0] oRegData;
  logic        oErr;

  int checks;
  int failures;

  load_store_unit dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iValid      (iValid),
    .iRead       (iRead),
    .iWrite      (iWrite),
    .iAddr       (iAddr),
    .iData       (iData),
    .iOpType     (iOpType),
    .iRdAddr     (iRdAddr),
    .oReady      (oReady),
    .oDmemReq    (oDmemReq),
    .oDmemWe     (oDmemWe),
    .oDmemAddr   (oDmemAddr),
    .oDmemWdata  (oDmemWdata),
    .oDmemBe     (oDmemBe),
    .iDmemGnt    (iDmemGnt),
    .iDmemRvalid (iDmemRvalid),
    .iDmemRdata  (iDmemRdata),
    .oRegDv      (oRegDv),
    .oRegAddr    (oRegAddr),
    .oRegData    (oRegData),
    .oErr        (oErr)
  );

  // Free-running 10 ns clock.
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Advance one clock and settle 1 ns past the edge, where outputs are
  // sampled and the next cycle's inputs are driven.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] op, input logic [4:0] rdA);
    iValid  = v;
    iRead   = rd;
    iWrite  = wr;
    iAddr   = a;
    iData   = d;
    iOpType = op;
    iRdAddr = rdA;
  endtask

  task automatic clearStimulus();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
  endtask

  // Minimum-latency load: accept, grant immediately, rvalid the next cycle.
  // Returns what the DUT showed at each step for the caller to compare.
  task automatic runLoad(input logic [31:0] a, input logic [2:0] op,
                         input logic [4:0] rdA, input logic [31:0] rdata,
                         output logic reqSeen, output logic [31:0] reqAddr,
                         output logic [3:0] reqBe, output logic dv,
                         output logic [4:0] dvAddr, output logic [31:0] dvData);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 32'd0, op, rdA);
    tick();
    clearStimulus();
    reqSeen  = oDmemReq;
    reqAddr  = oDmemAddr;
    reqBe    = oDmemBe;
    iDmemGnt = 1'b1;
    tick();
    iDmemGnt    = 1'b0;
    iDmemRvalid = 1'b1;
    iDmemRdata  = rdata;
    tick();
    iDmemRvalid = 1'b0;
    iDmemRdata  = 32'd0;
    dv     = oRegDv;
    dvAddr = oRegAddr;
    dvData = oRegData;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;
    checks++; if (oReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", oReady); end
    checks++; if (oDmemReq !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", oDmemReq); end
    checks++; if (oRegDv !== 1'b0) begin failures++; $display("[TB] FAIL reset_regdv got=%b exp=0", oRegDv); end
    checks++; if (oErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", oErr); end
    checks++; if (oRegData !== 32'd0) begin failures++; $display("[TB] FAIL reset_regdata got=%h exp=0", oRegData); end
    checks++; if (oDmemAddr !== 32'd0 || oDmemBe !== 4'd0) begin failures++; $display("[TB] FAIL reset_port got=%h/%b exp=0/0", oDmemAddr, oDmemBe); end
  endtask

  task automatic test_load_word();
    logic req, dv;
    logic [31:0] ra, dd;
    logic [3:0] be;
    logic [4:0] da;
    runLoad(32'h100, 3'b010, 5'd5, 32'hDEADBEEF, req, ra, be, dv, da, dd);
    checks++; if (req !== 1'b1) begin failures++; $display("[TB] FAIL lw_req got=%b exp=1", req); end
    checks++; if (ra !== 32'h100) begin failures++; $display("[TB] FAIL lw_addr got=%h exp=00000100", ra); end
    checks++; if (be !== 4'b1111) begin failures++; $display("[TB] FAIL lw_be got=%b exp=1111", be); end
    checks++; if (dv !== 1'b1) begin failures++; $display("[TB] FAIL lw_dv got=%b exp=1", dv); end
    checks++; if (da !== 5'd5) begin failures++; $display("[TB] FAIL lw_rd got=%0d exp=5", da); end
    checks++; if (dd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL lw_data got=%h exp=deadbeef", dd); end
    tick();
    checks++; if (oRegDv !== 1'b0) begin failures++; $display("[TB] FAIL lw_dv_pulse got=%b exp=0", oRegDv); end
    checks++; if (oRegData !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL lw_data_hold got=%h exp=deadbeef", oRegData); end
  endtask

  task automatic test_load_sub_word();
    logic req, dv;
    logic [31:0] ra, dd;
    logic [3:0] be;
    logic [4:0] da;
    runLoad(32'h103, 3'b000, 5'd3, 32'h80112233, req, ra, be, dv, da, dd);
    checks++; if (dd !== 32'hFFFFFF80 || dv !== 1'b1) begin failures++; $display("[TB] FAIL lb got=%h dv=%b exp=ffffff80 dv=1", dd, dv); end
    checks++; if (be !== 4'b1000) begin failures++; $display("[TB] FAIL lb_be got=%b exp=1000", be); end
    runLoad(32'h103, 3'b100, 5'd4, 32'h80112233, req, ra, be, dv, da, dd);
    checks++; if (dd !== 32'h00000080) begin failures++; $display("[TB] FAIL lbu got=%h exp=00000080", dd); end
    runLoad(32'h102, 3'b001, 5'd6, 32'h80010000, req, ra, be, dv, da, dd);
    checks++; if (dd !== 32'hFFFF8001) begin failures++; $display("[TB] FAIL lh got=%h exp=ffff8001", dd); end
    checks++; if (be !== 4'b1100) begin failures++; $display("[TB] FAIL lh_be got=%b exp=1100", be); end
    runLoad(32'h102, 3'b101, 5'd6, 32'h80010000, req, ra, be, dv, da, dd);
    checks++; if (dd !== 32'h00008001) begin failures++; $display("[TB] FAIL lhu got=%h exp=00008001", dd); end
    runLoad(32'h101, 3'b000, 5'd0, 32'h00007F00, req, ra, be, dv, da, dd);
    checks++; if (dv !== 1'b0) begin failures++; $display("[TB] FAIL rd0_dv got=%b exp=0", dv); end
  endtask

  task automatic test_store();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h102, 32'h0000ABCD, 3'b001, 5'd9);
    tick();
    clearStimulus();
    checks++; if (oDmemReq !== 1'b1 || oDmemWe !== 1'b1) begin failures++; $display("[TB] FAIL sh_req got=%b/%b exp=1/1", oDmemReq, oDmemWe); end
    checks++; if (oDmemBe !== 4'b1100) begin failures++; $display("[TB] FAIL sh_be got=%b exp=1100", oDmemBe); end
    checks++; if (oDmemWdata !== 32'hABCDABCD) begin failures++; $display("[TB] FAIL sh_wdata got=%h exp=abcdabcd", oDmemWdata); end
    checks++; if (oDmemAddr !== 32'h100) begin failures++; $display("[TB] FAIL sh_addr got=%h exp=00000100", oDmemAddr); end
    iDmemGnt = 1'b1;
    tick();
    iDmemGnt = 1'b0;
    checks++; if (oReady !== 1'b1 || oDmemReq !== 1'b0) begin failures++; $display("[TB] FAIL sh_done ready=%b req=%b exp=1/0", oReady, oDmemReq); end
    checks++; if (oRegDv !== 1'b0) begin failures++; $display("[TB] FAIL sh_no_wb got=%b exp=0", oRegDv); end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h101, 32'h0000005A, 3'b000, 5'd0);
    tick();
    clearStimulus();
    checks++; if (oDmemBe !== 4'b0010 || oDmemWdata !== 32'h5A5A5A5A) begin failures++; $display("[TB] FAIL sb got=%b/%h exp=0010/5a5a5a5a", oDmemBe, oDmemWdata); end
    iDmemGnt = 1'b1;
    tick();
    iDmemGnt = 1'b0;
  endtask

  task automatic test_grant_stall();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h104, 32'h11223344, 3'b010, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h200, 32'd0, 3'b010, 5'd8);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (oDmemReq !== 1'b1 || oReady !== 1'b0 || oDmemAddr !== 32'h104 ||
          oDmemBe !== 4'b1111 || oDmemWdata !== 32'h11223344) begin
        failures++;
        $display("[TB] FAIL stall_hold cyc=%0d req=%b rdy=%b addr=%h be=%b wd=%h exp=1/0/00000104/1111/11223344",
                 i, oDmemReq, oReady, oDmemAddr, oDmemBe, oDmemWdata);
      end
      tick();
    end
    clearStimulus();
    checks++; if (oDmemAddr !== 32'h104 || oDmemReq !== 1'b1) begin failures++; $display("[TB] FAIL stall_last addr=%h req=%b exp=00000104/1", oDmemAddr, oDmemReq); end
    iDmemGnt = 1'b1;
    tick();
    iDmemGnt = 1'b0;
    checks++; if (oReady !== 1'b1) begin failures++; $display("[TB] FAIL stall_ready got=%b exp=1", oReady); end
    tick();
    checks++; if (oDmemReq !== 1'b0) begin failures++; $display("[TB] FAIL stall_no_accept got=%b exp=0", oDmemReq); end
  endtask

  task automatic test_misaligned();
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h102, 32'd0, 3'b010, 5'd5);
    tick();
    clearStimulus();
    checks++; if (oErr !== 1'b1) begin failures++; $display("[TB] FAIL mis_err got=%b exp=1", oErr); end
    checks++; if (oDmemReq !== 1'b0 || oReady !== 1'b1) begin failures++; $display("[TB] FAIL mis_noreq req=%b rdy=%b exp=0/1", oDmemReq, oReady); end
    tick();
    checks++; if (oErr !== 1'b0 || oRegDv !== 1'b0) begin failures++; $display("[TB] FAIL mis_pulse err=%b dv=%b exp=0/0", oErr, oRegDv); end
`else
    logic req, dv;
    logic [31:0] ra, dd;
    logic [3:0] be;
    logic [4:0] da;
    runLoad(32'h102, 3'b010, 5'd5, 32'hCAFEF00D, req, ra, be, dv, da, dd);
    checks++; if (ra !== 32'h100 || req !== 1'b1) begin failures++; $display("[TB] FAIL mis_addr got=%h req=%b exp=00000100/1", ra, req); end
    checks++; if (dv !== 1'b1 || dd !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL mis_wb dv=%b data=%h exp=1/cafef00d", dv, dd); end
    checks++; if (oErr !== 1'b0) begin failures++; $display("[TB] FAIL mis_noerr got=%b exp=0", oErr); end
`endif
  endtask

  task automatic test_illegal();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 32'd0, 3'b010, 5'd5);
    tick();
    clearStimulus();
    checks++; if (oErr !== 1'b1 || oDmemReq !== 1'b0) begin failures++; $display("[TB] FAIL both_flags err=%b req=%b exp=1/0", oErr, oDmemReq); end
    tick();
    checks++; if (oErr !== 1'b0) begin failures++; $display("[TB] FAIL err_pulse got=%b exp=0", oErr); end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 3'b011, 5'd5);
    tick();
    clearStimulus();
    checks++; if (oErr !== 1'b1 || oDmemReq !== 1'b0) begin failures++; $display("[TB] FAIL bad_load_op err=%b req=%b exp=1/0", oErr, oDmemReq); end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'd0, 3'b100, 5'd0);
    tick();
    clearStimulus();
    checks++; if (oErr !== 1'b1 || oDmemReq !== 1'b0) begin failures++; $display("[TB] FAIL bad_store_op err=%b req=%b exp=1/0", oErr, oDmemReq); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 3'b010, 5'd7);
    tick();
    clearStimulus();
    iDmemGnt = 1'b1;
    tick();
    iDmemGnt = 1'b0;
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    iDmemRvalid = 1'b1;
    iDmemRdata  = 32'h12345678;
    tick();
    iDmemRvalid = 1'b0;
    checks++; if (oReady !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait_ready got=%b exp=1", oReady); end
    checks++; if (oRegDv !== 1'b0 || oErr !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_ignore dv=%b err=%b exp=0/0", oRegDv, oErr); end
    tick();
    checks++; if (oRegDv !== 1'b0 || oRegData !== 32'd0) begin failures++; $display("[TB] FAIL rst_wait_late dv=%b data=%h exp=0/0", oRegDv, oRegData); end
  endtask

  task automatic test_back_to_back();
    logic req, dv;
    logic [31:0] ra, dd;
    logic [3:0] be;
    logic [4:0] da;
    runLoad(32'h204, 3'b010, 5'd10, 32'h01020304, req, ra, be, dv, da, dd);
    checks++; if (dv !== 1'b1 || da !== 5'd10 || dd !== 32'h01020304) begin failures++; $display("[TB] FAIL b2b_first dv=%b rd=%0d data=%h exp=1/10/01020304", dv, da, dd); end
    runLoad(32'h209, 3'b001, 5'd11, 32'hAAAA7FFF, req, ra, be, dv, da, dd);
    checks++; if (req !== 1'b1 || ra !== 32'h208) begin failures++; $display("[TB] FAIL b2b_second_req req=%b addr=%h exp=1/00000208", req, ra); end
`ifndef LSU_MISALIGN_TRAP_EN
    checks++; if (dv !== 1'b1 || da !== 5'd11 || dd !== 32'h00007FFF) begin failures++; $display("[TB] FAIL b2b_second dv=%b rd=%0d data=%h exp=1/11/00007fff", dv, da, dd); end
`endif
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    iRst        = 1'b1;
    iDmemGnt    = 1'b0;
    iDmemRvalid = 1'b0;
    iDmemRdata  = 32'd0;
    clearStimulus();
    test_reset();
    test_load_word();
    test_load_sub_word();
    test_store();
    test_grant_stall();
    test_misaligned();
    test_illegal();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
